// File: rtl/keypad_display_ctrl_if.sv
// rtl/keypad_display_ctrl_if.sv - keypad / transcoder / display signal bundle for keypad_display_ctrl
interface keypad_display_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                  key_valid;
    logic [7:0]            key_code;
    logic [7:0]            tx_code;
    logic [6:0]            tx_seg;
    logic [6:0]            seg_n;
    logic [NUM_DIGITS-1:0] an_n;
    logic [3:0]            digit_count;
    logic                  ovf;

    modport master (
        output key_valid, key_code, tx_seg,
        input  tx_code, seg_n, an_n, digit_count, ovf
    );

    modport slave (
        input  key_valid, key_code, tx_seg,
        output tx_code, seg_n, an_n, digit_count, ovf
    );
endinterface

// File: rtl/keypad_display_ctrl.sv
// rtl/keypad_display_ctrl.sv - keypad digit buffer and multiplexed display sequencer (option: KEYPAD_LEADING_ZERO_EN)
module keypad_display_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    keypad_display_ctrl_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] CNT_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [3:0]       COUNT_FULL = 4'(NUM_DIGITS);
    localparam logic [7:0]       BLANK      = 8'h00;
    localparam logic [7:0]       KEY_BS     = 8'h0E;
    localparam logic [7:0]       KEY_CLR    = 8'h01;

    logic [7:0]            slot_q [NUM_DIGITS];
    logic [7:0]            slot_d [NUM_DIGITS];
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            tx_code;

    function automatic logic is_hex(input logic [7:0] c);
        case (c)
            8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
            8'h0A, 8'h0B, 8'h1E, 8'h30, 8'h2E, 8'h20, 8'h12, 8'h21: is_hex = 1'b1;
            default:                                                is_hex = 1'b0;
        endcase
    endfunction

    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (bus.key_valid && !bus.key_code[7]) begin
            if (is_hex(bus.key_code)) begin
                for (int i = NUM_DIGITS - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
                slot_d[0] = bus.key_code;
                if (count_q == COUNT_FULL) ovf_d = 1'b1;
                else                       count_d = count_q + 1'b1;
            end else if (bus.key_code == KEY_BS) begin
                // Slots above digit_count are always blank, so count 0 means nothing to remove
                if (count_q != 4'd0) begin
                    for (int i = 0; i < NUM_DIGITS - 1; i++) slot_d[i] = slot_q[i+1];
                    slot_d[NUM_DIGITS-1] = BLANK;
                    count_d = count_q - 1'b1;
                end
            end else if (bus.key_code == KEY_CLR) begin
                for (int i = 0; i < NUM_DIGITS; i++) slot_d[i] = BLANK;
                count_d = 4'd0;
                ovf_d   = 1'b0;
            end
        end
    end

    always_comb begin
        tx_code = slot_q[idx_q];
`ifdef KEYPAD_LEADING_ZERO_EN
        if (tx_code == BLANK) tx_code = 8'h0B;
`endif
    end

    // Pattern and enable are registered together from the same index so they never disagree
    always_comb begin
        seg_d = bus.tx_seg;
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) slot_q[i] <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
            seg_q   <= 7'h7F;
            an_q    <= '1;
        end else begin
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.tx_code     = tx_code;
    assign bus.seg_n       = seg_q;
    assign bus.an_n        = an_q;
    assign bus.digit_count = count_q;
    assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_keypad_display_ctrl.sv
// tb/tb_keypad_display_ctrl.sv - self-checking bench for keypad_display_ctrl with a behavioural transcoder
module tb_keypad_display_ctrl;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int DW = 16;
`ifdef KEYPAD_LEADING_ZERO_EN
    localparam logic [7:0] BLANK_CODE = 8'h0B;
    localparam logic [6:0] BLANK_SEG  = 7'h40;
`else
    localparam logic [7:0] BLANK_CODE = 8'h00;
    localparam logic [6:0] BLANK_SEG  = 7'h7F;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_display_ctrl_if #(.NUM_DIGITS(ND)) bus();

    keypad_display_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DIV_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [6:0] seg_of(input logic [7:0] c);
        case (c)
            8'h0B: seg_of = 7'h40; 8'h02: seg_of = 7'h79; 8'h03: seg_of = 7'h24; 8'h04: seg_of = 7'h30;
            8'h05: seg_of = 7'h19; 8'h06: seg_of = 7'h12; 8'h07: seg_of = 7'h02; 8'h08: seg_of = 7'h78;
            8'h09: seg_of = 7'h00; 8'h0A: seg_of = 7'h10; 8'h1E: seg_of = 7'h08; 8'h30: seg_of = 7'h03;
            8'h2E: seg_of = 7'h46; 8'h20: seg_of = 7'h21; 8'h12: seg_of = 7'h06; 8'h21: seg_of = 7'h0E;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    function automatic logic [7:0] disp(input logic [7:0] c);
        disp = (c == 8'h00) ? BLANK_CODE : c;
    endfunction

    always_comb bus.tx_seg = seg_of(bus.tx_code);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: slots packed as {slot3,slot2,slot1,slot0}
    logic [31:0] m_word;
    int          m_cnt, m_idx, m_count;
    logic        m_ovf;
    logic [10:0] sb[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            sb.push_back({7'h7F, 4'hF});
            m_word = 32'h0; m_cnt = 0; m_idx = 0; m_count = 0; m_ovf = 1'b0;
        end else begin
            sb.push_back({seg_of(disp(m_word[8*m_idx +: 8])), 4'(~(4'b0001 << m_idx))});
            if (bus.key_valid && !bus.key_code[7]) begin
                if (bus.key_code inside {8'h0B, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                         8'h09, 8'h0A, 8'h1E, 8'h30, 8'h2E, 8'h20, 8'h12, 8'h21}) begin
                    if (m_count == ND) m_ovf = 1'b1;
                    else               m_count++;
                    m_word = {m_word[23:0], bus.key_code};
                end else if (bus.key_code == 8'h0E && m_count > 0) begin
                    m_count--;
                    m_word = {8'h00, m_word[31:8]};
                end else if (bus.key_code == 8'h01) begin
                    m_count = 0; m_ovf = 1'b0; m_word = 32'h0;
                end
            end
            if (m_cnt == RD - 1) begin m_cnt = 0; m_idx = (m_idx + 1) % ND; end
            else m_cnt++;
        end
    end

    always @(negedge clk) begin
        logic [10:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("scoreboard {seg_n,an_n}", {bus.seg_n, bus.an_n}, e);
        end
    end

    task automatic press(input logic [7:0] c);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic check_slots(input logic [31:0] exp, input string tag);
        int kk;
        for (int c = 0; c < RD * ND; c++) begin
            @(negedge clk);
            kk = -1;
            for (int k = 0; k < ND; k++) if (bus.an_n == 4'(~(4'b0001 << k))) kk = k;
            if (kk < 0) begin
                n_checks++; n_fail++;
                $display("FAIL %s an_n onehot: got %0h expected one-hot low", tag, bus.an_n);
            end else begin
                chk($sformatf("%s digit %0d seg_n", tag, kk), bus.seg_n, seg_of(disp(exp[8*kk +: 8])));
            end
        end
    endtask

    typedef struct {
        logic [7:0]  code;
        int          count;
        logic        ovf;
        logic [31:0] slots;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit   found;
        int   saved_idx;

        vecs.push_back('{8'h02, 1, 1'b0, 32'h00000002});
        vecs.push_back('{8'h03, 2, 1'b0, 32'h00000203});
        vecs.push_back('{8'h1E, 3, 1'b0, 32'h0002031E});
        vecs.push_back('{8'h01, 0, 1'b0, 32'h00000000});
        vecs.push_back('{8'h02, 1, 1'b0, 32'h00000002});
        vecs.push_back('{8'h03, 2, 1'b0, 32'h00000203});
        vecs.push_back('{8'h04, 3, 1'b0, 32'h00020304});
        vecs.push_back('{8'h06, 4, 1'b0, 32'h02030406});
        vecs.push_back('{8'h07, 4, 1'b1, 32'h03040607});
        vecs.push_back('{8'h0E, 3, 1'b1, 32'h00030406});
        vecs.push_back('{8'h01, 0, 1'b0, 32'h00000000});
        vecs.push_back('{8'h02, 1, 1'b0, 32'h00000002});
        vecs.push_back('{8'h03, 2, 1'b0, 32'h00000203});
        vecs.push_back('{8'h0E, 1, 1'b0, 32'h00000002});
        vecs.push_back('{8'h0E, 0, 1'b0, 32'h00000000});
        vecs.push_back('{8'h0E, 0, 1'b0, 32'h00000000});
        vecs.push_back('{8'h02, 1, 1'b0, 32'h00000002});
        vecs.push_back('{8'h82, 1, 1'b0, 32'h00000002});
        vecs.push_back('{8'h1C, 1, 1'b0, 32'h00000002});
        vecs.push_back('{8'h01, 0, 1'b0, 32'h00000000});

        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset seg_n", bus.seg_n, 7'h7F);
        chk("reset an_n", bus.an_n, 4'hF);
        chk("reset digit_count", bus.digit_count, 4'd0);
        chk("reset ovf", bus.ovf, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle an_n cycle %0d", i), bus.an_n, 4'(~(4'b0001 << ((i / RD) % ND))));
            chk($sformatf("idle seg_n cycle %0d", i), bus.seg_n, BLANK_SEG);
        end

        for (int r = 0; r < vecs.size(); r++) begin
            press(vecs[r].code);
            chk($sformatf("row %0d digit_count", r), bus.digit_count, vecs[r].count);
            chk($sformatf("row %0d ovf", r), bus.ovf, vecs[r].ovf);
            check_slots(vecs[r].slots, $sformatf("row %0d", r));
        end

        found = 1'b0;
        for (int w = 0; w < 2 * RD && !found; w++) begin
            @(negedge clk);
            if (m_cnt == RD - 1) found = 1'b1;
        end
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL terminal-count wait: got timeout expected m_cnt==%0d", RD - 1);
        end
        saved_idx     = m_idx;
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h04;
        @(negedge clk);
        bus.key_valid = 1'b0;
        chk("key+tc digit_count", bus.digit_count, 4'd1);
        @(negedge clk);
        chk("key+tc an_n advanced", bus.an_n, 4'(~(4'b0001 << ((saved_idx + 1) % ND))));
        check_slots(32'h00000004, "key+tc");

        for (int i = 0; i < 5; i++) press(8'h05);
        chk("pre-reset ovf", bus.ovf, 1'b1);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h02;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.key_valid = 1'b0;
        chk("mid reset seg_n", bus.seg_n, 7'h7F);
        chk("mid reset an_n", bus.an_n, 4'hF);
        chk("mid reset digit_count", bus.digit_count, 4'd0);
        chk("mid reset ovf", bus.ovf, 1'b0);
        chk("mid reset tx_code", bus.tx_code, BLANK_CODE);
        @(negedge clk);
        chk("key lost digit_count", bus.digit_count, 4'd0);
        check_slots(32'h00000000, "after reset");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
